// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - D-stage branch/jump sequencer with delay-slot tracking
//
// Classifies the D-stage control transfer, holds it in WAIT while operands
// are not forwarded, resolves the condition/target, issues a one-cycle
// redirect and marks the following instruction as a delay slot.
//
// Optional build macro: BRANCH_STATS_EN (taken/not-taken/wait counters).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   id_valid, id_stall    D-stage valid / hazard stall
//   br_sel                transfer class (0 none, 1..6 cond, 7 j, 8 jr)
//   rs_val, rt_val        forwarded operands
//   id_pc, imm16          D-stage PC and branch offset
//   instr_index           j/jal index field
//   flush                 CP0 exception/eret flush
//   npc_sel, npc_target   combinational redirect to F
//   id_bd, br_busy        registered delay-slot flag / WAIT indicator
//   slot_err              registered pulse: transfer seen in a delay slot
//   taken_cnt, nt_cnt, wait_cnt  statistics counters (0 without the macro)

module branch_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic [3:0]       br_sel,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic [31:0]      id_pc,
  input  logic [15:0]      imm16,
  input  logic [25:0]      instr_index,
  input  logic             flush,
  output logic             npc_sel,
  output logic [31:0]      npc_target,
  output logic             id_bd,
  output logic             br_busy,
  output logic             slot_err,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nt_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SLOT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        pending;
  logic        resolve;
  logic        cond_taken;
  logic        slot_err_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] target;

  always_comb begin
    pending = id_valid && (br_sel >= 4'd1) && (br_sel <= 4'd8);
  end

  always_comb begin
    pc_plus4  = id_pc + 32'd4;
    br_offset = {{14{imm16[15]}}, imm16, 2'b00};
  end

  always_comb begin
    cond_taken = 1'b0;
    target     = pc_plus4 + br_offset;
    case (br_sel)
      4'd1: cond_taken = (rs_val == rt_val);
      4'd2: cond_taken = (rs_val != rt_val);
      4'd3: cond_taken = rs_val[31] || (rs_val == 32'd0);
      4'd4: cond_taken = !rs_val[31] && (rs_val != 32'd0);
      4'd5: cond_taken = rs_val[31];
      4'd6: cond_taken = !rs_val[31];
      4'd7: begin
        cond_taken = 1'b1;
        target     = {pc_plus4[31:28], instr_index, 2'b00};
      end
      4'd8: begin
        cond_taken = 1'b1;
        target     = rs_val;
      end
      default: cond_taken = 1'b0;
    endcase
  end

  // Next state. flush overrides everything, including a resolve in the same
  // cycle; a transfer seen in SLOT never resolves, it only flags slot_err
  // once, when the offending slot instruction advances.
  always_comb begin
    state_nxt    = state;
    resolve      = 1'b0;
    slot_err_nxt = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (pending) begin
            if (id_stall) begin
              state_nxt = WAIT;
            end else begin
              resolve   = 1'b1;
              state_nxt = SLOT;
            end
          end
        end
        WAIT: begin
          if (!pending) begin
            state_nxt = IDLE;
          end else if (!id_stall) begin
            resolve   = 1'b1;
            state_nxt = SLOT;
          end
        end
        SLOT: begin
          if (id_valid && !id_stall) begin
            state_nxt    = IDLE;
            slot_err_nxt = pending;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    npc_sel    = resolve && cond_taken && !reset;
    npc_target = npc_sel ? target : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      id_bd    <= 1'b0;
      br_busy  <= 1'b0;
      slot_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      id_bd    <= (state_nxt == SLOT);
      br_busy  <= (state_nxt == WAIT);
      slot_err <= slot_err_nxt;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_q;
  logic [CNT_W-1:0] nt_q;
  logic [CNT_W-1:0] wait_q;

  // resolve already excludes flush, so a flushed cycle never counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_q <= '0;
      nt_q    <= '0;
      wait_q  <= '0;
    end else begin
      if (resolve && cond_taken) begin
        taken_q <= taken_q + 1'b1;
      end
      if (resolve && !cond_taken) begin
        nt_q <= nt_q + 1'b1;
      end
      if ((state == WAIT) && !flush) begin
        wait_q <= wait_q + 1'b1;
      end
    end
  end

  assign taken_cnt = taken_q;
  assign nt_cnt    = nt_q;
  assign wait_cnt  = wait_q;
`else
  assign taken_cnt = '0;
  assign nt_cnt    = '0;
  assign wait_cnt  = '0;
`endif

endmodule
